// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 figures, counter width and frame-total helper.
package vga_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate tick generator: one tick every CLK_DIV clocks while enabled; phase freezes when enable is low.
// Reset clears the phase, so the first tick after release lands CLK_DIV clocks later.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic pix_tick
);

  if (CLK_DIV == 1) begin : g_pass
    assign pix_tick = enable & ~rst;
  end else begin : g_div
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        div_cnt <= '0;
      end else if (enable) begin
        div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
      end
    end

    assign pix_tick = enable & ~rst & (div_cnt == LAST);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters on the pixel tick, colour and sync registered together (1 pixel tick latency).
// Define VGA_TEST_PATTERN_EN to build the 8-bar colour pattern selected by test_mode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 4,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic [COLOR_BITS-1:0] pix_r,
  input  logic [COLOR_BITS-1:0] pix_g,
  input  logic [COLOR_BITS-1:0] pix_b,
  input  logic                  test_mode,
  output logic [CNT_W-1:0]      x,
  output logic [CNT_W-1:0]      y,
  output logic                  pix_req,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  frame_start,
  output logic                  line_start
);

  localparam int   H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  logic                  pix_tick;
  cnt_t                  hcnt;
  cnt_t                  vcnt;
  logic                  active;
  logic                  h_wrap;
  logic                  v_wrap;
  logic                  hs_now;
  logic                  vs_now;
  logic [COLOR_BITS-1:0] col_r;
  logic [COLOR_BITS-1:0] col_g;
  logic [COLOR_BITS-1:0] col_b;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .enable   (enable),
    .pix_tick (pix_tick)
  );

  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);
  assign hs_now = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_now = (vcnt >= VS_BEG) && (vcnt < VS_END);

  assign x           = active ? hcnt : '0;
  assign y           = active ? vcnt : '0;
  assign pix_req     = pix_tick & active;
  assign line_start  = pix_tick & h_wrap;
  assign frame_start = pix_tick & h_wrap & v_wrap;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'((int'(hcnt) * 8) / H_ACTIVE);

  always_comb begin
    col_r = pix_r;
    col_g = pix_g;
    col_b = pix_b;
    if (test_mode) begin
      col_r = {COLOR_BITS{bar[2]}};
      col_g = {COLOR_BITS{bar[1]}};
      col_b = {COLOR_BITS{bar[0]}};
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    col_r = pix_r;
    col_g = pix_g;
    col_b = pix_b;
  end
`endif

  // Blanking while disabled takes effect on the very next clock, not the next tick.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !enable) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= SYNC_OFF;
      vsync <= SYNC_OFF;
    end else if (pix_tick) begin
      red   <= active ? col_r : '0;
      green <= active ? col_g : '0;
      blue  <= active ? col_b : '0;
      hsync <= hs_now ? SYNC_ON : SYNC_OFF;
      vsync <= vs_now ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = CD * HT * VT;
  localparam int HS_START = HA + HF;
  localparam int VS_START = VA + VF;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_req;
    logic       hsync;
    logic       vsync;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       fs;
    logic       ls;
  } obs_t;

  typedef struct {
    string name;
    int    exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       wb_rst_i, enable, test_mode;
  logic [3:0] pix_r, pix_g, pix_b;
  logic [9:0] x, y;
  logic       pix_req, hsync, vsync, frame_start, line_start;
  logic [3:0] red, green, blue;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t last_got;
  obs_t rst_obs;
  vec_t vecs[8];
  int   ev[8];

  int   m_pos, m_phase;
  logic m_hs, m_vs;
  logic [3:0] m_r, m_g, m_b;

  int   cyc, cyc_total = 0;
  bit   track = 0;
  int   first_ls, first_fs, hs_fall, hs_rise, vs_fall, vs_rise, n_pix, n_ls;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .COLOR_BITS (4),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV (CD),
    .SYNC_POL (0)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .enable      (enable),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .test_mode   (test_mode),
    .x           (x),
    .y           (y),
    .pix_req     (pix_req),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference raster: linear tick position within the frame plus divider phase.
  function automatic obs_t model_out(input logic r, input logic en);
    obs_t o;
    int   h, v;
    logic act, tick;
    h = m_pos % HT;
    v = m_pos / HT;
    act = (h < HA) && (v < VA);
    tick = !r && en && (m_phase == CD - 1);
    o.x = act ? 10'(h) : 10'd0;
    o.y = act ? 10'(v) : 10'd0;
    o.pix_req = tick && act;
    o.hsync = m_hs;
    o.vsync = m_vs;
    o.r = m_r;
    o.g = m_g;
    o.b = m_b;
    o.ls = tick && (h == HT - 1);
    o.fs = tick && (h == HT - 1) && (v == VT - 1);
    return o;
  endfunction

  task automatic model_update(input logic r, input logic en, input logic tm,
                              input logic [3:0] pr, input logic [3:0] pg, input logic [3:0] pb);
    int h, v;
    logic [2:0] bar;
    h = m_pos % HT;
    v = m_pos / HT;
    if (r) begin
      m_pos = 0; m_phase = 0;
      m_r = 0; m_g = 0; m_b = 0; m_hs = 1; m_vs = 1;
    end else if (!en) begin
      m_r = 0; m_g = 0; m_b = 0; m_hs = 1; m_vs = 1;
    end else if (m_phase == CD - 1) begin
      if (h < HA && v < VA) begin
        if (tm && TP) begin
          bar = 3'(h / (HA / 8));
          m_r = bar[2] ? 4'hF : 4'h0;
          m_g = bar[1] ? 4'hF : 4'h0;
          m_b = bar[0] ? 4'hF : 4'h0;
        end else begin
          m_r = pr; m_g = pg; m_b = pb;
        end
      end else begin
        m_r = 0; m_g = 0; m_b = 0;
      end
      m_hs = !(h >= HS_START && h < HS_START + HS);
      m_vs = !(v >= VS_START && v < VS_START + VS);
      m_pos = (m_pos + 1) % (HT * VT);
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic track_events(input obs_t g);
    if (g.ls && first_ls < 0) first_ls = cyc;
    if (g.fs && first_fs < 0) first_fs = cyc;
    if (!g.hsync && hs_fall < 0) hs_fall = cyc;
    if (g.hsync && hs_fall >= 0 && hs_rise < 0) hs_rise = cyc;
    if (!g.vsync && vs_fall < 0) vs_fall = cyc;
    if (g.vsync && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
    if (cyc < FRAME) begin
      if (g.pix_req) n_pix++;
      if (g.ls) n_ls++;
    end
  endtask

  // One clock: drive, push expectation, compare at negedge, advance model at posedge.
  task automatic step(input logic r, input logic en, input logic tm);
    obs_t e, g;
    logic [3:0] pr, pg, pb;
    int h, v;
    h = m_pos % HT;
    v = m_pos / HT;
    pr = (h < HA && v < VA) ? 4'(h) : 4'd0;
    pg = 4'(v);
    pb = 4'($urandom_range(0, 15));
    wb_rst_i = r; enable = en; test_mode = tm;
    pix_r = pr; pix_g = pg; pix_b = pb;
    sb.push_back(model_out(r, en));
    @(negedge clk);
    g = {x, y, pix_req, hsync, vsync, red, green, blue, frame_start, line_start};
    e = sb.pop_front();
    check($sformatf("out@%0d", cyc_total), g, e);
    last_got = g;
    if (track) track_events(g);
    cyc++;
    cyc_total++;
    @(posedge clk);
    model_update(r, en, tm, pr, pg, pb);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n, k;
    vecs[0] = '{"first_line_start",  CD * HT - 1};
    vecs[1] = '{"first_frame_start", CD * HT * VT - 1};
    vecs[2] = '{"hsync_fall",        CD * HS_START + CD};
    vecs[3] = '{"hsync_low_clks",    CD * HS};
    vecs[4] = '{"vsync_fall",        CD * HT * VS_START + CD};
    vecs[5] = '{"vsync_low_clks",    CD * HT * VS};
    vecs[6] = '{"pix_req_per_frame", HA * VA};
    vecs[7] = '{"lines_per_frame",   VT};
    rst_obs = '{x: 10'd0, y: 10'd0, pix_req: 1'b0, hsync: 1'b1, vsync: 1'b1,
                r: 4'd0, g: 4'd0, b: 4'd0, fs: 1'b0, ls: 1'b0};
    first_ls = -1; first_fs = -1; hs_fall = -1; hs_rise = -1;
    vs_fall = -1; vs_rise = -1; n_pix = 0; n_ls = 0;

    wb_rst_i = 1; enable = 0; test_mode = 0; pix_r = 0; pix_g = 0; pix_b = 0;
    repeat (2) @(posedge clk);
    #1;
    model_update(1, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    check("reset_state", last_got, rst_obs);
    step(1, 1, 0);

    // Free-running frame plus margin, timing events measured from reset release.
    cyc = 0;
    track = 1;
    repeat (FRAME + 200) step(0, 1, 0);
    track = 0;
    ev = '{first_ls, first_fs, hs_fall, hs_rise - hs_fall, vs_fall, vs_rise - vs_fall, n_pix, n_ls};
    for (int i = 0; i < 8; i++) check(vecs[i].name, ev[i], vecs[i].exp);

    // Enable drop mid-line: counters freeze, colour blanks, sync idle, then resume in place.
    n = 0;
    while (!((m_pos % HT) == 10 && m_phase == 0) && n < FRAME) begin
      step(0, 1, 0);
      n++;
    end
    if (n >= FRAME) timeout("seek_hold_point");
    repeat (50) step(0, 0, 0);
    check("hold_x", last_got.x, 10);
    check("hold_red", last_got.r, 0);
    check("hold_hsync", last_got.hsync, 1);
    step(0, 1, 0);
    check("resume_x", last_got.x, 10);
    step(0, 1, 0);
    step(0, 1, 0);
    check("resume_x_next", last_got.x, 11);
    check("resume_red", last_got.r, 10);

    // One-clock reset mid-frame with enable held high.
    n = 0;
    while (!(m_pos == 4 * HT + 5 && m_phase == 0) && n < 2 * FRAME) begin
      step(0, 1, 0);
      n++;
    end
    if (n >= 2 * FRAME) timeout("seek_reset_point");
    step(1, 1, 0);
    step(0, 1, 0);
    check("post_rst_out", last_got, rst_obs);
    k = 0;
    while (!last_got.pix_req && k < 8) begin
      step(0, 1, 0);
      k++;
    end
    check("post_rst_first_tick", k, CD - 1);
    check("post_rst_xy", {last_got.x, last_got.y}, 0);

    // Test pattern request: bars with the macro, ignored without it.
    repeat (CD * HT * 2) step(0, 1, 1);
    repeat (CD * 4) step(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter COLOR_BITS, default 4, meaning width of each of red/green/blue.
REQ-002 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, meaning vertical timing in lines.
REQ-004 SHALL have parameter CLK_DIV, default 2 (legal 1..16), meaning system clocks per pixel.
REQ-005 SHALL have parameter SYNC_POL, default 0, meaning sync active level (0 = active-low).
REQ-006 wb_clk_i  in  1  sole clock.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  run timing; when low, counters hold and outputs blank.
REQ-009 pix_r / pix_g / pix_b  in  COLOR_BITS each  pixel colour for the current (x, y).
REQ-010 test_mode  in  1  select internal pattern (effective only per REQ-030).
REQ-011 x  out  10  current active column; y  out  10  current active row.
REQ-012 pix_req  out  1  high during the pixel tick when (x, y) is inside the active area.
REQ-013 hsync, vsync  out  1  registered sync outputs; red/green/blue  out  COLOR_BITS  registered colour.
REQ-014 frame_start  out  1  one-clock pulse; line_start  out  1  one-clock pulse.

Function
REQ-015 SHALL produce pix_tick once every CLK_DIV clocks while enable=1; pix_tick SHALL be constantly 1 when CLK_DIV=1.
REQ-016 SHALL advance hcnt on pix_tick over 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters), then wrap to 0 and advance vcnt.
REQ-017 SHALL advance vcnt over 0..V_TOTAL-1, wrapping to 0 when hcnt and vcnt both wrap on the same tick.
REQ-018 Active area SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE, with x=hcnt and y=vcnt; x and y SHALL read 0 outside the active area.
REQ-019 Sync SHALL be asserted when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vcnt.
REQ-020 Output stage SHALL register colour and sync together on pix_tick, giving exactly 1 pixel tick of latency from (x, y) to the colour on the pins.
REQ-021 Colour outputs SHALL be 0 whenever the registered pixel is outside the active area.
REQ-022 line_start SHALL pulse for one clock on the pix_tick where hcnt wraps to 0; frame_start SHALL pulse only when vcnt also wraps to 0.
REQ-023 When enable falls, counters SHALL freeze, colour SHALL go 0 on the next clock, and sync SHALL go to its inactive level.
REQ-024 When enable rises, counting SHALL resume from the frozen position without any reset of the counters.

Reset
REQ-025 While wb_rst_i=1 at a clock edge: hcnt=0, vcnt=0, divider=0, red/green/blue=0, hsync=vsync=inactive, pix_req=0, frame_start=0, line_start=0, x=0, y=0.
REQ-026 Reset asserted mid-frame SHALL override enable; the first pix_tick after release SHALL occur CLK_DIV clocks later, with hcnt=0 and vcnt=0.
REQ-027 Reset SHALL NOT be asynchronous; no output SHALL change except at a wb_clk_i edge.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN SHALL gate the built-in pattern generator.
REQ-029 Without the macro: test_mode SHALL be ignored, and no pattern logic SHALL be synthesised.
REQ-030 With the macro and test_mode=1: colour SHALL be 8 vertical bars of width H_ACTIVE/8.
REQ-031 Bar index i SHALL be x*8/H_ACTIVE, giving red={COLOR_BITS{i[2]}}, green={COLOR_BITS{i[1]}}, blue={COLOR_BITS{i[0]}}; pix_* SHALL be ignored.

Structure
REQ-032 Shared package vga_pkg SHALL hold the default 640x480 timing constants, the derived H_TOTAL/V_TOTAL function, and the counter width constant (10).
REQ-033 One sub-module, vga_pix_div (CLK_DIV tick generator, with enable and synchronous reset), SHALL be instantiated.

Verification
REQ-034 Reset, then enable=1 with CLK_DIV=2 -> first line_start and frame_start pulse at the wrap from hcnt=799 and vcnt=524; frame period = 800*525*2 = 840000 clocks.
REQ-035 Check hsync low for exactly 96 ticks starting at hcnt=656 -> 192 clocks; check vsync low for exactly 2 lines starting at vcnt=490.
REQ-036 Drive pix_r = x[3:0] -> red on the pins equals x of the previous tick, and is 0 on the ticks for hcnt 640..799.
REQ-037 Deassert enable at hcnt=300 for 50 clocks -> counters hold, colour=0, sync inactive; resume at hcnt=300.
REQ-038 Assert wb_rst_i for 1 clock at vcnt=200 -> all outputs reach reset values next edge; frame restarts at 0,0.
REQ-039 With VGA_TEST_PATTERN_EN and test_mode=1 -> x=0 gives {0,0,0}, x=80 gives blue=4'hF, x=639 gives all 4'hF.
